fetch_unit: RTL and testbench

- Instruction-fetch front end for the pipelined core.
- Generates the sequential PC (PC+4), issues instruction-memory reads over a valid/ready request plus response interface, and buffers returned instructions with their PCs in a small queue.
- Presents the queue head to decode.
- Accepts branch redirects, which flush the queue and retarget fetch; the PC-select function is absorbed here, as the consumer of the branch target and select.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end: default widths,
//   the sequential PC step, the request FSM states and the fetch-queue entry.
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_INSTR_W = 32;

  // Byte distance between sequential instruction words.
  localparam int PC_STEP = 4;

  // IDLE : no request outstanding, may issue.
  // WAIT : live request outstanding, its response will be queued.
  // DRAIN: stale request outstanding (redirected), its response is dropped.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]  pc;
    logic [DEFAULT_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch entries. Flush empties it in one cycle and
//   takes priority over push and pop. The head entry is always presented;
//   it is only meaningful while count != 0.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data at the tail (caller guarantees room)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   flush       discard every entry
//   count       number of valid entries, 0..DEPTH
//   head        oldest entry
// ----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset too, so the head (and thus if_pc/if_instr)
      // reads zero out of reset instead of X.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Keeps the fetch PC, issues one instruction
//   memory read at a time, queues returned words with their PCs and presents
//   the queue head to decode. A branch redirect flushes the queue, retargets
//   the PC and marks any outstanding read as stale.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    read request valid
//   imem_req_addr     read address (word aligned, = fetch PC)
//   imem_req_ready    memory accepts the request this cycle
//   imem_rsp_valid    read data valid (one per accepted request)
//   imem_rsp_data     read data
//   redirect_valid    redirect fetch this cycle
//   redirect_target   new fetch PC (low two bits ignored)
//   if_valid          queue head valid
//   if_pc, if_instr   queue head PC and instruction
//   if_ready          decode consumes the head this cycle
// ----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               if_ready
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int                CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(3);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] target_aligned;
  logic [CW-1:0]     count;
  logic              accept;
  logic              push;
  logic              pop;
  entry_t            head;
  entry_t            push_entry;

  assign target_aligned = redirect_target & ALIGN;

  // Issue only with room for the answer: count + outstanding never exceeds
  // DEPTH, so the queue cannot overflow. Gated by rst_n so the request drops
  // the moment reset is asserted.
  assign imem_req_valid = rst_n && (state == IDLE) && (count < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response that lands together with a redirect belongs to the old path.
  assign push       = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign push_entry = '{pc: req_pc, instr: imem_rsp_data};

  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

  // NOTE: every always_comb output gets its default first so no path leaves
  // it unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;

    if (accept) begin
      fetch_pc_nxt = fetch_pc + STEP;
    end
    if (redirect_valid) begin
      fetch_pc_nxt = target_aligned;
    end

    unique case (state)
      IDLE: begin
        // A request accepted in the redirect cycle is already stale.
        if (accept) begin
          state_nxt = redirect_valid ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = IDLE;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (accept) begin
        req_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model keeps the list of
//   instructions decode should see, whether a read is outstanding and whether
//   it still belongs to the current path, plus a small instruction memory
//   with configurable response latency.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [7:0]  imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        if_valid;
  logic [7:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model.
  ent_t        exp_q[$];
  logic [7:0]  exp_pc;
  bit          busy;
  bit          live;
  logic [7:0]  out_pc;

  // Instruction memory model.
  logic [31:0] mem [64];
  bit          mem_pending;
  int          mem_wait;
  logic [7:0]  mem_addr;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready)
  );

  always #5 clk = ~clk;

  // Compares DUT outputs with the model, drives one cycle of inputs, advances
  // the model over the coming edge and returns 1 time unit after the next
  // falling edge.
  task automatic step(input bit rdy, input bit ird, input bit redir,
                      input logic [7:0] tgt, input int lat);
    bit exp_rv, acc, rsp, pop;
    exp_rv = !busy && (exp_q.size() < DEPTH);

    n_total++;
    if (imem_req_valid !== exp_rv)
      $display("FAIL req_valid: got %b, expected %b at %0t", imem_req_valid, exp_rv, $time);
    else n_pass++;
    if (exp_rv) begin
      n_total++;
      if (imem_req_addr !== exp_pc)
        $display("FAIL req_addr: got %h, expected %h at %0t", imem_req_addr, exp_pc, $time);
      else n_pass++;
    end
    n_total++;
    if (if_valid !== (exp_q.size() != 0))
      $display("FAIL if_valid: got %b, expected %b at %0t", if_valid, exp_q.size() != 0, $time);
    else n_pass++;
    if (exp_q.size() != 0) begin
      n_total++;
      if (if_pc !== exp_q[0].pc || if_instr !== exp_q[0].instr)
        $display("FAIL if_head: got %h/%h, expected %h/%h at %0t",
                 if_pc, if_instr, exp_q[0].pc, exp_q[0].instr, $time);
      else n_pass++;
    end

    rsp = 1'b0;
    if (mem_pending) begin
      if (mem_wait == 0) rsp = 1'b1;
      else mem_wait--;
    end
    imem_rsp_valid  = rsp;
    imem_rsp_data   = rsp ? mem[mem_addr[7:2]] : $urandom;
    imem_req_ready  = rdy && !mem_pending;
    if_ready        = ird;
    redirect_valid  = redir;
    redirect_target = tgt;

    acc = exp_rv && imem_req_ready;
    pop = (exp_q.size() != 0) && ird;

    if (rsp) mem_pending = 1'b0;
    if (acc) begin
      mem_pending = 1'b1;
      mem_wait    = lat - 1;
      mem_addr    = exp_pc;
    end

    if (redir) begin
      exp_q.delete();
      if (busy) begin
        if (rsp) busy = 1'b0;
        else live = 1'b0;
      end else if (acc) begin
        busy = 1'b1;
        live = 1'b0;
      end
      exp_pc = {tgt[7:2], 2'b00};
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (busy && rsp) begin
        if (live) exp_q.push_back('{out_pc, imem_rsp_data});
        busy = 1'b0;
      end
      if (acc) begin
        busy   = 1'b1;
        live   = 1'b1;
        out_pc = exp_pc;
        exp_pc = exp_pc + 8'd4;
      end
    end

    @(negedge clk);
    #1;
  endtask

  // Holds reset for two cycles and releases it just after a falling edge.
  task automatic do_reset(input bit keep_mem);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready       = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_pc = 8'h00;
    busy   = 1'b0;
    live   = 1'b0;
    if (!keep_mem) mem_pending = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid);
    else n_pass++;
    n_total++;
    if (imem_req_addr !== 8'h00) $display("FAIL rst_req_addr: got %h, expected 00", imem_req_addr);
    else n_pass++;
    n_total++;
    if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b, expected 0", if_valid);
    else n_pass++;
    n_total++;
    if (if_pc !== 8'h00 || if_instr !== 32'h0)
      $display("FAIL rst_head: got %h/%h, expected 00/00000000", if_pc, if_instr);
    else n_pass++;
    do_reset(1'b0);
  endtask

  // Fast memory, decode always ready: PCs 00,04,08 in order, first valid
  // two cycles after reset release.
  task automatic test_stream();
    int first = -1;
    logic [7:0] seen[$];
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (if_valid && first < 0) first = i;
      if (if_valid) seen.push_back(if_pc);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1);
    end
    n_total++;
    if (first != 2) $display("FAIL stream_first_valid: got cycle %0d, expected 2", first);
    else n_pass++;
    n_total++;
    if (seen.size() < 3 || seen[0] !== 8'h00 || seen[1] !== 8'h04 || seen[2] !== 8'h08)
      $display("FAIL stream_order: got %0d entries starting %h, expected 00,04,08",
               seen.size(), (seen.size() != 0) ? seen[0] : 8'hxx);
    else n_pass++;
  endtask

  // Decode stalled: the queue fills to DEPTH and fetch stops, then drains in
  // order and resumes at 10.
  task automatic test_fill();
    bit resumed = 1'b0;
    logic [7:0] popped[$];
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1);
    n_total++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 8'h00)
      $display("FAIL fill_full: got req_valid %b if_valid %b pc %h, expected 0/1/00",
               imem_req_valid, if_valid, if_pc);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (imem_req_valid && !resumed) begin
        resumed = 1'b1;
        n_total++;
        if (imem_req_addr !== 8'h10)
          $display("FAIL fill_resume: got %h, expected 10", imem_req_addr);
        else n_pass++;
      end
      if (if_valid) popped.push_back(if_pc);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1);
    end
    n_total++;
    if (!resumed) $display("FAIL fill_resume_timeout: got no request, expected one");
    else n_pass++;
    n_total++;
    if (popped.size() < 4 || popped[0] !== 8'h00 || popped[1] !== 8'h04 ||
        popped[2] !== 8'h08 || popped[3] !== 8'h0C)
      $display("FAIL fill_order: got %0d pops, expected 00,04,08,0C first", popped.size());
    else n_pass++;
  endtask

  // Redirect while a read is outstanding: its data is dropped and the first
  // delivered instruction comes from 40.
  task automatic test_redirect_wait();
    logic [7:0] first_pc = 8'hxx;
    bit got = 1'b0;
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 3);
    step(1'b1, 1'b1, 1'b1, 8'h40, 1);
    for (int i = 0; i < 12; i++) begin
      if (if_valid && !got) begin got = 1'b1; first_pc = if_pc; end
      step(1'b1, 1'b1, 1'b0, 8'h00, 1);
    end
    n_total++;
    if (!got || first_pc !== 8'h40)
      $display("FAIL redir_wait_pc: got %h (valid seen %b), expected 40", first_pc, got);
    else n_pass++;
  endtask

  // Redirect to an unaligned target in the same cycle as the response.
  task automatic test_redirect_rsp();
    do_reset(1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 2);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1);
    step(1'b1, 1'b1, 1'b1, 8'h43, 1);
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 8'h40 || if_valid !== 1'b0)
      $display("FAIL redir_rsp: got req %b addr %h if_valid %b, expected 1/40/0",
               imem_req_valid, imem_req_addr, if_valid);
    else n_pass++;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 1);
  endtask

  // PC wraps from FC to 00.
  task automatic test_wrap();
    logic [7:0] seen[$];
    do_reset(1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hFC, 1);
    for (int i = 0; i < 10; i++) begin
      if (if_valid) seen.push_back(if_pc);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1);
    end
    n_total++;
    if (seen.size() < 2 || seen[0] !== 8'hFC || seen[1] !== 8'h00)
      $display("FAIL wrap_order: got %0d entries, expected FC then 00", seen.size());
    else n_pass++;
  endtask

  // Reset while WAIT with two entries queued; the late response is ignored.
  task automatic test_reset_mid();
    logic [7:0] first_pc = 8'hxx;
    bit got = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 3);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 8'h00)
      $display("FAIL mid_reset: got if_valid %b req %b addr %h, expected 0/0/00",
               if_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (if_valid && !got) begin got = 1'b1; first_pc = if_pc; end
      step(1'b1, 1'b1, 1'b0, 8'h00, 1);
    end
    n_total++;
    if (!got || first_pc !== 8'h00)
      $display("FAIL mid_reset_restart: got %h (valid seen %b), expected 00", first_pc, got);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, 8'($urandom),
           int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem_pending = 1'b0;
    mem_wait    = 0;
    mem_addr    = '0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
